// File: rtl/vline_irq_gen.sv
// vline_irq_gen
//   Raster-driven interrupt generator and ROM bank latch for Konami-style Z80
//   mains. Counts vertical-line steps and raises NCH maskable channels at
//   power-of-two step periods. Each channel is routed to INT or NMI.
//
// Ports
//   CPUCL   : clock, all state on rising edge
//   RESET   : synchronous, active-high
//   PV      : current vertical line from the video timing generator
//   seed    : tick value loaded at the first frame start after reset
//   CPUAD   : CPU address
//   CPUWD   : CPU write data
//   CPUWE   : qualified memory write strobe (MREQ & WR)
//   cpu_irq : INT request, active-high level (registered)
//   cpu_nmi : NMI request, active-high level (registered)
//   pend    : per-channel pending flags
//   ROMBK   : ROM bank select
//   rd_dv   : status read valid          (VIRQ_STATUS_EN only)
//   rd_dt   : status read data, pend     (VIRQ_STATUS_EN only)
//
// Build option
//   VIRQ_STATUS_EN : when defined, adds the combinational pend status read
//                    port decoded at ACK_ADDR.

module vline_irq_gen #(
  parameter int unsigned        NCH       = 3,
  parameter int unsigned        TICKW     = 9,
  parameter int unsigned        STEP_LOG2 = 4,
  parameter logic [4*NCH-1:0]   TAPS      = {4'd4, 4'd3, 4'd0},
  parameter logic [NCH-1:0]     NMI_MAP   = 3'b001,
  parameter logic [15:0]        MASK_ADDR = 16'hE044,
  parameter logic [15:0]        ACK_ADDR  = 16'hE045,
  parameter logic [15:0]        BANK_ADDR = 16'hF000,
  parameter int unsigned        BANKW     = 3,
  parameter int unsigned        BANK_LSB  = 5
) (
  input  logic             CPUCL,
  input  logic             RESET,
  input  logic [8:0]       PV,
  input  logic [TICKW-1:0] seed,
  input  logic [15:0]      CPUAD,
  input  logic [7:0]       CPUWD,
  input  logic             CPUWE,
  output logic             cpu_irq,
  output logic             cpu_nmi,
  output logic [NCH-1:0]   pend,
  output logic [BANKW-1:0] ROMBK
`ifdef VIRQ_STATUS_EN
  ,
  output logic             rd_dv,
  output logic [7:0]       rd_dt
`endif
);

  localparam logic [8:0] STEP_MSK = 9'((1 << STEP_LOG2) - 1);

  typedef enum logic {
    ST_WAIT_SYNC,
    ST_FREE_RUN
  } sync_t;

  sync_t            state_q;
  sync_t            state_d;
  logic [TICKW-1:0] tick;
  logic [8:0]       ppv;
  logic [NCH-1:0]   irqmask;
  logic [NCH-1:0]   pend_d;
  logic [NCH-1:0]   ch_fire;
  logic [TICKW-1:0] fire;
  logic [TICKW-1:0] fire_sh;
  logic             mask_hit;
  logic             ack_hit;
  logic             bank_hit;
  logic             wr_hit;
  logic             line_evt;
  logic             step;
  logic             load_seed;
  logic             unused_wd;

  assign unused_wd = &{1'b0, CPUWD};

  // CPU write decode
  assign mask_hit = CPUWE && (CPUAD == MASK_ADDR);
  assign ack_hit  = CPUWE && (CPUAD == ACK_ADDR);
  assign bank_hit = CPUWE && (CPUAD == BANK_ADDR);
  assign wr_hit   = mask_hit || ack_hit || bank_hit;

  // A pending line event is left unconsumed (ppv untouched) while a decoded
  // write is on the bus, so it is taken on the first write-free cycle.
  assign line_evt = (ppv != PV) && ((PV & STEP_MSK) == '0);
  assign step     = line_evt && !wr_hit;

  // Lowest clear bit of the pre-update tick: bit k is set once every
  // 2**(k+1) steps.
  assign fire = ~tick & (tick + TICKW'(1));

  always_comb begin
    ch_fire = '0;
    fire_sh = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      fire_sh    = fire >> TAPS[4*i +: 4];
      ch_fire[i] = fire_sh[0];
    end
  end

  // Writes and steps are mutually exclusive, so set and clear never collide.
  always_comb begin
    pend_d = pend;
    if (mask_hit) begin
      pend_d = pend & CPUWD[NCH-1:0];
    end else if (ack_hit) begin
      pend_d = pend & ~CPUWD[NCH-1:0];
    end else if (step) begin
      pend_d = pend | (ch_fire & irqmask);
    end
  end

  // Frame-sync FSM: state register
  always_ff @(posedge CPUCL) begin
    if (RESET) begin
      state_q <= ST_WAIT_SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  // Frame-sync FSM: next state
  always_comb begin
    state_d = state_q;
    if ((state_q == ST_WAIT_SYNC) && step && (PV == '0)) begin
      state_d = ST_FREE_RUN;
    end
  end

  // Frame-sync FSM: outputs
  always_comb begin
    load_seed = (state_q == ST_WAIT_SYNC) && step && (PV == '0);
  end

  always_ff @(posedge CPUCL) begin
    if (RESET) begin
      tick    <= '0;
      ppv     <= 9'd1;
      irqmask <= '0;
      pend    <= '0;
      cpu_irq <= 1'b0;
      cpu_nmi <= 1'b0;
      ROMBK   <= '0;
    end else begin
      pend    <= pend_d;
      cpu_nmi <= |(pend & NMI_MAP);
      cpu_irq <= |(pend & ~NMI_MAP);
      if (mask_hit) begin
        irqmask <= CPUWD[NCH-1:0];
      end
      if (bank_hit) begin
        ROMBK <= CPUWD[BANK_LSB +: BANKW];
      end
      if (step) begin
        ppv  <= PV;
        tick <= load_seed ? seed : tick + TICKW'(1);
      end
    end
  end

`ifdef VIRQ_STATUS_EN
  always_comb begin
    rd_dv = (CPUAD == ACK_ADDR) && !CPUWE;
    rd_dt = rd_dv ? 8'(pend) : '0;
  end
`endif

endmodule

// File: tb/tb_vline_irq_gen.sv
module tb_vline_irq_gen;

  localparam logic [15:0] MASK_A = 16'hE044;
  localparam logic [15:0] ACK_A  = 16'hE045;
  localparam logic [15:0] BANK_A = 16'hF000;

  int tap     [3] = '{0, 3, 4};
  int nmi_sel [3] = '{1, 0, 0};

  logic        CPUCL = 1'b0;
  logic        RESET = 1'b0;
  logic [8:0]  PV    = 9'd0;
  logic [8:0]  seed  = 9'd0;
  logic [15:0] CPUAD = 16'h0000;
  logic [7:0]  CPUWD = 8'h00;
  logic        CPUWE = 1'b0;
  logic        cpu_irq;
  logic        cpu_nmi;
  logic [2:0]  pend;
  logic [2:0]  ROMBK;
`ifdef VIRQ_STATUS_EN
  logic        rd_dv;
  logic [7:0]  rd_dt;
`endif

  vline_irq_gen dut (
    .CPUCL   (CPUCL),
    .RESET   (RESET),
    .PV      (PV),
    .seed    (seed),
    .CPUAD   (CPUAD),
    .CPUWD   (CPUWD),
    .CPUWE   (CPUWE),
    .cpu_irq (cpu_irq),
    .cpu_nmi (cpu_nmi),
    .pend    (pend),
    .ROMBK   (ROMBK)
`ifdef VIRQ_STATUS_EN
    ,
    .rd_dv   (rd_dv),
    .rd_dt   (rd_dt)
`endif
  );

  always #5 CPUCL = ~CPUCL;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: integer arithmetic on the documented rules.
  bit m_valid = 0;
  bit m_sync;
  int m_tick, m_ppv, m_mask, m_pend, m_irq, m_nmi, m_bank;
  int nirq, nnmi, d;
  bit evt;

  always @(posedge CPUCL) begin
    if (RESET) begin
      m_tick = 0; m_ppv = 1; m_sync = 1; m_mask = 0; m_pend = 0;
      m_irq = 0; m_nmi = 0; m_bank = 0; m_valid = 1;
    end else if (m_valid) begin
      nirq = 0; nnmi = 0;
      for (int i = 0; i < 3; i++)
        if ((m_pend >> i) % 2 == 1) begin
          if (nmi_sel[i] == 1) nnmi = 1; else nirq = 1;
        end
      d   = int'(CPUWD);
      evt = (int'(PV) != m_ppv) && (int'(PV) % 16 == 0);
      if (CPUWE && CPUAD == MASK_A) begin
        m_mask = d % 8;
        m_pend = m_pend & d;
      end else if (CPUWE && CPUAD == ACK_A) begin
        m_pend = m_pend & ~d & 7;
      end else if (CPUWE && CPUAD == BANK_A) begin
        m_bank = (d / 32) % 8;
      end else if (evt) begin
        for (int i = 0; i < 3; i++)
          if ((m_tick % (1 << (tap[i] + 1))) == (1 << tap[i]) - 1 && (m_mask >> i) % 2 == 1)
            m_pend = m_pend | (1 << i);
        if (m_sync && int'(PV) == 0) begin
          m_tick = int'(seed);
          m_sync = 0;
        end else begin
          m_tick = (m_tick + 1) % 512;
        end
        m_ppv = int'(PV);
      end
      m_irq = nirq;
      m_nmi = nnmi;
    end
  end

  always @(negedge CPUCL) begin
    if (m_valid) begin
      check("pend",    32'(pend),    32'(m_pend));
      check("cpu_irq", 32'(cpu_irq), 32'(m_irq));
      check("cpu_nmi", 32'(cpu_nmi), 32'(m_nmi));
      check("ROMBK",   32'(ROMBK),   32'(m_bank));
`ifdef VIRQ_STATUS_EN
      check("rd_dv", 32'(rd_dv), 32'((CPUAD == ACK_A && !CPUWE) ? 1 : 0));
      check("rd_dt", 32'(rd_dt), 32'((CPUAD == ACK_A && !CPUWE) ? m_pend : 0));
`endif
    end
  end

  task automatic cyc();
    @(posedge CPUCL);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] v);
    CPUAD = a; CPUWD = v; CPUWE = 1'b1;
    cyc();
    CPUWE = 1'b0;
  endtask

  int hold = 0;
  int line = 0;
  int pvv  = 0;

  initial begin
    // Directed sequence with hand-computed expectations.
    RESET = 1'b1; PV = 9'd255; seed = 9'd48;
    cyc();
    RESET = 1'b0;
    check("rst_pend", 32'(pend), 0);
    check("rst_irq",  32'(cpu_irq), 0);
    check("rst_nmi",  32'(cpu_nmi), 0);
    check("rst_bank", 32'(ROMBK), 0);

    wr(MASK_A, 8'h07);
    PV = 9'd0;
    cyc();                                   // tick 0 fires ch0, seed loaded
    check("f0_pend", 32'(pend), 32'h1);
    cyc();
    check("f0_nmi", 32'(cpu_nmi), 1);
    check("f0_irq", 32'(cpu_irq), 0);

    wr(ACK_A, 8'h01);
    check("ack_pend", 32'(pend), 0);
    check("ack_nmi_lag", 32'(cpu_nmi), 1);
    cyc();
    check("ack_nmi", 32'(cpu_nmi), 0);

    PV = 9'd16;
    wr(MASK_A, 8'h07);                       // write wins over the line event
    check("wr_evt_pend", 32'(pend), 0);
    cyc();                                   // deferred step, tick 48
    check("def_step_pend", 32'(pend), 32'h1);

    wr(BANK_A, 8'hA0);
    check("bank", 32'(ROMBK), 32'h5);
    check("bank_pend", 32'(pend), 32'h1);
    check("bank_irq", 32'(cpu_irq), 0);

    for (int v = 32; v <= 112; v += 16) begin
      PV = 9'(v);
      cyc();
    end
    check("pre_ch1_pend", 32'(pend), 32'h1);
    PV = 9'd128;
    cyc();                                   // tick 55 fires ch1
    check("ch1_pend", 32'(pend), 32'h3);
    cyc();
    check("ch1_irq", 32'(cpu_irq), 1);
    check("ch1_nmi", 32'(cpu_nmi), 1);

`ifdef VIRQ_STATUS_EN
    CPUAD = ACK_A;
    #1;
    check("stat_dv", 32'(rd_dv), 1);
    check("stat_dt", 32'(rd_dt), 32'h03);
    cyc();
    check("stat_noside", 32'(pend), 32'h3);
`endif

    RESET = 1'b1;
    cyc();
    RESET = 1'b0;
    check("mid_rst_pend", 32'(pend), 0);
    check("mid_rst_irq",  32'(cpu_irq), 0);
    check("mid_rst_nmi",  32'(cpu_nmi), 0);
    check("mid_rst_bank", 32'(ROMBK), 0);

    // Randomized traffic against the model.
    seed = 9'($urandom);
    pvv  = 0;
    PV   = 9'd0;
    for (int c = 0; c < 8000; c++) begin
      RESET = ($urandom_range(0, 999) < 2);
      if (RESET) seed = 9'($urandom);
      if (hold > 0) begin
        hold--;
      end else begin
        CPUWE = 1'b0;
        CPUAD = ($urandom_range(0, 3) == 0) ? ACK_A : 16'h0000;
        if ($urandom_range(0, 99) < 8) begin
          case ($urandom_range(0, 3))
            0: begin
              CPUAD = MASK_A;
              CPUWD = 8'($urandom);
              if ($urandom_range(0, 3) != 0) CPUWD = CPUWD | 8'h07;
            end
            1: begin CPUAD = ACK_A;    CPUWD = 8'($urandom); end
            2: begin CPUAD = BANK_A;   CPUWD = 8'($urandom); end
            default: begin CPUAD = 16'hE046; CPUWD = 8'($urandom); end
          endcase
          CPUWE = 1'b1;
          hold  = $urandom_range(0, 2);
        end
      end
      if (line > 0) begin
        line--;
      end else begin
        if ($urandom_range(0, 199) == 0) pvv = $urandom_range(0, 511);
        else pvv = (pvv + 1) % 256;
        PV   = 9'(pvv);
        line = $urandom_range(0, 1);
      end
      cyc();
    end
    RESET = 1'b0;
    CPUWE = 1'b0;
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
